// File: rtl/half_stream_serialize_pkg.sv
// Shared fp16 types, field widths and the serializer FSM encoding.
// Imported by half_stream_serialize and, when HALF_STREAM_FTZ_EN is defined, by half_ftz.
package half_stream_pkg;

  localparam int HALF_EXP_W = 5;
  localparam int HALF_MAN_W = 10;

  typedef logic [15:0] half_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic logic is_subnormal(input half_t h);
    return (h[HALF_MAN_W +: HALF_EXP_W] == '0) && (h[HALF_MAN_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/half_stream_serialize_if.sv
// Vector-in / element-out bus of the serializer.
// The slave modport is the serializer's view; the master modport is the producer/consumer side.
interface half_stream_if #(
  parameter int BITS   = 16,
  parameter int LENGTH = 10
);
  localparam int IW = $clog2(LENGTH) + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [LENGTH*BITS-1:0] vec;
  logic                   out_valid;
  logic [BITS-1:0]        out_data;
  logic                   out_last;
  logic [IW-1:0]          out_index;

  modport master (
    output in_valid, vec,
    input  in_ready, out_valid, out_data, out_last, out_index
  );

  modport slave (
    input  in_valid, vec,
    output in_ready, out_valid, out_data, out_last, out_index
  );
endinterface

// File: rtl/half_stream_serialize_ftz.sv
// Combinational subnormal flush-to-zero on one fp16 word (sign kept).
// Only compiled when HALF_STREAM_FTZ_EN is defined, which is also the only build that instantiates it.
`ifdef HALF_STREAM_FTZ_EN
module half_ftz
  import half_stream_pkg::*;
(
  input  half_t din,
  output half_t dout
);
  assign dout = is_subnormal(din) ? {din[15], 15'b0} : din;
endmodule
`endif

// File: rtl/half_stream_serialize.sv
// Double-buffered vector-to-element serializer feeding the fp16 streaming accumulator.
// Optional HALF_STREAM_FTZ_EN flushes subnormal out_data words to signed zero (BITS==16 only).
//
// state  | meaning
// IDLE   | nothing streaming, outputs held at zero, ready for a vector
// STREAM | one element of the active vector presented per cycle
module half_stream_serialize
  import half_stream_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int LENGTH = 10
) (
  input  logic           clk,
  input  logic           rstn,
  half_stream_if.slave   bus
);
  localparam int IW = $clog2(LENGTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LENGTH - 1);

  state_t                 state;
  logic [LENGTH*BITS-1:0] active;
  logic [LENGTH*BITS-1:0] pending;
  logic                   pend_valid;
  logic [IW-1:0]          idx;
  logic [BITS-1:0]        data_q;
  logic                   valid_q;
  logic                   last_q;
  logic                   xfer;
  logic [IW-1:0]          idx_nxt;

  function automatic logic [BITS-1:0] elem(input logic [LENGTH*BITS-1:0] v,
                                           input logic [IW-1:0] i);
    return v[int'(i)*BITS +: BITS];
  endfunction

  assign xfer    = bus.in_valid && !pend_valid;
  assign idx_nxt = idx + IW'(1);

  // idx always names the element currently on the outputs; out_last is precomputed for it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      active     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      idx        <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            active  <= bus.vec;
            idx     <= '0;
            data_q  <= elem(bus.vec, IW'(0));
            valid_q <= 1'b1;
            last_q  <= (LAST_IDX == IW'(0));
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (idx == LAST_IDX) begin
            if (pend_valid) begin
              active     <= pending;
              pend_valid <= 1'b0;
              idx        <= '0;
              data_q     <= elem(pending, IW'(0));
              last_q     <= (LAST_IDX == IW'(0));
            end else if (xfer) begin
              // Bypass: a vector arriving on the last beat goes straight to active.
              active <= bus.vec;
              idx    <= '0;
              data_q <= elem(bus.vec, IW'(0));
              last_q <= (LAST_IDX == IW'(0));
            end else begin
              state   <= IDLE;
              idx     <= '0;
              data_q  <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end
          end else begin
            idx    <= idx_nxt;
            data_q <= elem(active, idx_nxt);
            last_q <= (idx_nxt == LAST_IDX);
            if (xfer) begin
              pending    <= bus.vec;
              pend_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ~pend_valid;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.out_index = idx;

`ifdef HALF_STREAM_FTZ_EN
  generate
    if (BITS == 16) begin : g_ftz
      half_t ftz_out;
      half_ftz u_ftz (
        .din  (half_t'(data_q)),
        .dout (ftz_out)
      );
      assign bus.out_data = ftz_out;
    end else begin : g_no_ftz
      assign bus.out_data = data_q;
    end
  endgenerate
`else
  assign bus.out_data = data_q;
`endif

endmodule

// File: tb/tb_half_stream_serialize.sv
// Scoreboard bench for half_stream_serialize: accepted vectors are expanded into a timed
// expected-element queue; a negedge monitor compares every cycle. A LENGTH=1 instance gets directed checks.
module tb_half_stream_serialize;
  localparam int BITS = 16;
  localparam int L    = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  half_stream_if #(.BITS(BITS), .LENGTH(L)) bus ();
  half_stream_serialize #(.BITS(BITS), .LENGTH(L)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  half_stream_if #(.BITS(BITS), .LENGTH(1)) bus1 ();
  half_stream_serialize #(.BITS(BITS), .LENGTH(1)) dut1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus1.slave)
  );

  typedef struct {
    int          cyc;
    logic [15:0] data;
    int          index;
    logic        last;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int next_free = 0;
  int pend_c = -1;
  int pend_end = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // A vector waits in the pending slot from the cycle after acceptance until its burst starts.
  function automatic logic model_ready(input int n);
    return !(n > pend_c && n <= pend_end);
  endfunction

  function automatic logic [15:0] model_word(input logic [15:0] x);
`ifdef HALF_STREAM_FTZ_EN
    if (x[14:10] == 5'd0 && x[9:0] != 10'd0) return {x[15], 15'd0};
`endif
    return x;
  endfunction

  function automatic logic [15:0] rand_half();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0: r[14:10] = 5'd0;
      1: r[14:10] = 5'h1f;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [L*BITS-1:0] rand_vec();
    logic [L*BITS-1:0] v;
    for (int i = 0; i < L; i++) v[i*BITS +: BITS] = rand_half();
    return v;
  endfunction

  task automatic accept(input logic [L*BITS-1:0] d);
    int start;
    start = (cyc + 1 > next_free) ? cyc + 1 : next_free;
    if (start > cyc + 1) begin
      pend_c   = cyc;
      pend_end = start - 1;
    end
    for (int i = 0; i < L; i++)
      q.push_back('{cyc: start + i, data: model_word(d[i*BITS +: BITS]), index: i, last: (i == L - 1)});
    next_free = start + L;
  endtask

  task automatic drive(input logic v, input logic [L*BITS-1:0] d, output logic acc);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.vec      = d;
    @(negedge clk);
    acc = rstn && v && model_ready(cyc);
    if (acc) accept(d);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) drive(1'b0, rand_vec(), a);
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("in_ready", 32'(bus.in_ready), 32'(model_ready(cyc)));
    if (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missed_element", 32'(q[0].cyc), 32'(cyc));
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("out_data", 32'(bus.out_data), 32'(e.data));
      chk("out_index", 32'(bus.out_index), 32'(e.index));
      chk("out_last", 32'(bus.out_last), 32'(e.last));
    end else begin
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_data", 32'(bus.out_data), 32'd0);
      chk("idle_index", 32'(bus.out_index), 32'd0);
      chk("idle_last", 32'(bus.out_last), 32'd0);
    end
  end

  initial begin
    logic acc;
    int got;
    logic [L*BITS-1:0] v;
    bus.in_valid  = 1'b0;
    bus.vec       = '0;
    bus1.in_valid = 1'b0;
    bus1.vec      = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2);

    // single vector, elements 3C00,4000,4200,4400
    drive(1'b1, {16'h4400, 16'h4200, 16'h4000, 16'h3C00}, acc);
    idle(6);

    // three vectors back-to-back with in_valid held high
    got = 0;
    for (int k = 0; k < 40 && got < 3; k++) begin
      drive(1'b1, rand_vec(), acc);
      if (acc) got++;
    end
    chk("b2b_accepted", 32'(got), 32'd3);
    idle(3 * L + 2);

    // bypass on the out_last cycle
    drive(1'b1, rand_vec(), acc);
    idle(L - 1);
    drive(1'b1, rand_vec(), acc);
    idle(L + 2);

    // reset while the element with index 2 is on the outputs
    drive(1'b1, rand_vec(), acc);
    idle(2);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    next_free = 0;
    pend_c = -1;
    pend_end = -1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(1'b1, rand_vec(), acc);
    idle(L + 2);

    // subnormals and specials through the output path
    drive(1'b1, {16'h7C01, 16'h0400, 16'h8001, 16'h0001}, acc);
    idle(L + 2);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      v = rand_vec();
      drive(($urandom_range(0, 3) != 0), v, acc);
    end
    idle(3 * L + 2);
    chk("queue_drained", 32'(q.size()), 32'd0);

    // LENGTH=1 instance: consecutive vectors, one per cycle
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b1;
    bus1.vec      = 16'h3C00;
    @(negedge clk);
    chk("l1_pre_valid", 32'(bus1.out_valid), 32'd0);
    chk("l1_pre_ready", 32'(bus1.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus1.vec = 16'hBC00;
    @(negedge clk);
    chk("l1_v0_valid", 32'(bus1.out_valid), 32'd1);
    chk("l1_v0_data", 32'(bus1.out_data), 32'h3C00);
    chk("l1_v0_last", 32'(bus1.out_last), 32'd1);
    chk("l1_v0_index", 32'(bus1.out_index), 32'd0);
    chk("l1_v0_ready", 32'(bus1.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    chk("l1_v1_valid", 32'(bus1.out_valid), 32'd1);
    chk("l1_v1_data", 32'(bus1.out_data), 32'hBC00);
    chk("l1_v1_last", 32'(bus1.out_last), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("l1_end_valid", 32'(bus1.out_valid), 32'd0);
    chk("l1_end_last", 32'(bus1.out_last), 32'd0);
    chk("l1_end_data", 32'(bus1.out_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
